// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg
// Shared definitions for the register-bench write arbiter: register address
// geometry, the link register index, default tuning parameters, the arbiter
// FSM state type and the write-request record driven onto the bench port.
package reg_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] LINK_REG = 5'd31;

  localparam int STARVE_LIMIT_DEFAULT    = 4;
  localparam int MAX_OUTSTANDING_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } arb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     word;
    logic                  link;
    logic                  set;
    logic                  cond;
  } wr_req_t;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if
// Bundles every request/response signal around the write arbiter.
//   WB side      : wb_valid, wb_rd, wb_word, wb_link, wb_set, wb_cond -> wb_stall
//   MCU issue    : mc_issue_valid, mc_issue_rd -> mc_issue_ready
//   MCU result   : mc_res_valid, mc_res_rd, mc_res_word -> mc_res_ready
//   Decode       : dec_rs1, dec_rs2, dec_rd -> dec_stall
//   Bench write  : enable_reg, Rd_back, word_back, link_back, set_back,
//                  condition_back
//   Status       : err_waw (sticky)
// master = the requesters and register bench, slave = the arbiter.
interface reg_write_arbiter_if;
  import reg_write_arbiter_pkg::*;

  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_word;
  logic                  wb_link;
  logic                  wb_set;
  logic                  wb_cond;
  logic                  wb_stall;

  logic                  mc_issue_valid;
  logic [REG_ADDR_W-1:0] mc_issue_rd;
  logic                  mc_issue_ready;

  logic                  mc_res_valid;
  logic [REG_ADDR_W-1:0] mc_res_rd;
  logic [DATA_W-1:0]     mc_res_word;
  logic                  mc_res_ready;

  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_stall;

  logic                  enable_reg;
  logic [REG_ADDR_W-1:0] Rd_back;
  logic [DATA_W-1:0]     word_back;
  logic                  link_back;
  logic                  set_back;
  logic                  condition_back;

  logic                  err_waw;

  modport master (
    output wb_valid, wb_rd, wb_word, wb_link, wb_set, wb_cond,
    output mc_issue_valid, mc_issue_rd,
    output mc_res_valid, mc_res_rd, mc_res_word,
    output dec_rs1, dec_rs2, dec_rd,
    input  wb_stall, mc_issue_ready, mc_res_ready, dec_stall,
    input  enable_reg, Rd_back, word_back, link_back, set_back, condition_back,
    input  err_waw
  );

  modport slave (
    input  wb_valid, wb_rd, wb_word, wb_link, wb_set, wb_cond,
    input  mc_issue_valid, mc_issue_rd,
    input  mc_res_valid, mc_res_rd, mc_res_word,
    input  dec_rs1, dec_rs2, dec_rd,
    output wb_stall, mc_issue_ready, mc_res_ready, dec_stall,
    output enable_reg, Rd_back, word_back, link_back, set_back, condition_back,
    output err_waw
  );

endinterface

// File: rtl/reg_write_arbiter_scoreboard.sv
// reg_write_arbiter_scoreboard
// Tracks which registers are destinations of MCU ops still in flight and how
// many MCU ops are outstanding.
//   clk, reset              : clock, async active-high reset
//   issue_valid/issue_rd    : decode wants to issue an MCU op
//   issue_ready             : fewer than MAX_OUTSTANDING ops in flight
//   retire/retire_rd        : an MCU result is written back this cycle
//   look_rs1/rs2/rd         : decode operands to test against pending bits
//   look_hit                : a nonzero operand is pending
//   pending                 : raw pending bit vector (bit 0 never set)
module reg_write_arbiter_scoreboard
  import reg_write_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  retire,
  input  logic [REG_ADDR_W-1:0] retire_rd,
  input  logic [REG_ADDR_W-1:0] look_rs1,
  input  logic [REG_ADDR_W-1:0] look_rs2,
  input  logic [REG_ADDR_W-1:0] look_rd,
  output logic                  look_hit,
  output logic [NUM_REGS-1:0]   pending
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [OUT_W-1:0]    outstanding;
  logic                issue_fire;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  assign issue_ready = (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign issue_fire  = issue_valid && issue_ready;

  // r0 is never tracked; an op writing r0 still counts as outstanding.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_fire && (issue_rd != '0)) set_mask[issue_rd] = 1'b1;
    if (retire) clr_mask[retire_rd] = 1'b1;
  end

  // Set is OR'd in after the clear so a same-register issue wins over retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({issue_fire, retire})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign look_hit = ((look_rs1 != '0) && pending[look_rs1]) ||
                    ((look_rs2 != '0) && pending[look_rs2]) ||
                    ((look_rd  != '0) && pending[look_rd]);

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Owns the single write port of the 32-entry register bench and shares it
// between the WB stage and the multi-cycle unit. WB normally wins; an MCU
// result that has been blocked STARVE_LIMIT cycles is force-granted next.
// Also drives the decode hazard stall from the MCU destination scoreboard
// and flags WB writes to registers an MCU op still owns.
//   clk, reset : clock, async active-high reset
//   bus        : reg_write_arbiter_if.slave (all request/response signals)
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT    = STARVE_LIMIT_DEFAULT,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_write_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t          state;
  arb_state_t          state_next;
  logic [CNT_W-1:0]    starve_cnt;
  logic [CNT_W-1:0]    starve_cnt_next;
  logic [CNT_W-1:0]    starve_cnt_inc;

  logic                wb_grant;
  logic                mc_grant;
  logic                mc_write;
  logic                waw_hit;
  logic                err_waw_q;
  logic                issue_ready;
  logic                dec_hit;
  logic [NUM_REGS-1:0] pending;
  wr_req_t             wr;

  // In FORCE the MCU result takes the port whatever WB wants; otherwise WB
  // has priority and the MCU only gets an otherwise idle port.
  assign mc_grant = bus.mc_res_valid && ((state == FORCE) || !bus.wb_valid);
  assign wb_grant = bus.wb_valid && !mc_grant;
  // An MCU result for r0 is consumed but never reaches the bench.
  assign mc_write = mc_grant && (bus.mc_res_rd != '0);

  assign starve_cnt_inc = starve_cnt + CNT_W'(1);

  reg_write_arbiter_scoreboard #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (bus.mc_issue_valid),
    .issue_rd    (bus.mc_issue_rd),
    .issue_ready (issue_ready),
    .retire      (mc_grant),
    .retire_rd   (bus.mc_res_rd),
    .look_rs1    (bus.dec_rs1),
    .look_rs2    (bus.dec_rs2),
    .look_rd     (bus.dec_rd),
    .look_hit    (dec_hit),
    .pending     (pending)
  );

  assign bus.mc_issue_ready = issue_ready;

  // State register and starvation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Every cycle the MCU result loses to WB counts toward starvation, including
  // the first one seen from IDLE. Anything else (MCU granted, nothing pending,
  // or the result illegally withdrawn) returns to IDLE with the count cleared.
  always_comb begin
    state_next      = IDLE;
    starve_cnt_next = '0;
    case (state)
      IDLE, WAIT: begin
        if (bus.wb_valid && bus.mc_res_valid) begin
          starve_cnt_next = starve_cnt_inc;
          state_next      = (starve_cnt_inc == CNT_W'(STARVE_LIMIT)) ? FORCE : WAIT;
        end
      end
      FORCE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bench write port and handshake outputs, combinational from state+requests.
  always_comb begin
    wr = '0;
    if (wb_grant) begin
      wr.rd   = bus.wb_link ? LINK_REG : bus.wb_rd;
      wr.word = bus.wb_word;
      wr.link = bus.wb_link;
      wr.set  = bus.wb_set;
      wr.cond = bus.wb_cond;
    end else if (mc_write) begin
      wr.rd   = bus.mc_res_rd;
      wr.word = bus.mc_res_word;
    end

    bus.enable_reg     = wb_grant || mc_write;
    bus.Rd_back        = wr.rd;
    bus.word_back      = wr.word;
    bus.link_back      = wr.link;
    bus.set_back       = wr.set;
    bus.condition_back = wr.cond;
    bus.wb_stall       = bus.wb_valid && !wb_grant;
    bus.mc_res_ready   = mc_grant;
    bus.dec_stall      = dec_hit || (bus.mc_issue_valid && !issue_ready);
  end

  // A link write lands in r31 regardless of wb_rd, so both targets are checked.
  assign waw_hit = wb_grant &&
                   (((bus.wb_rd != '0) && pending[bus.wb_rd]) ||
                    (bus.wb_link && pending[LINK_REG]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err_waw_q <= 1'b0;
    else if (waw_hit) err_waw_q <= 1'b1;
  end

  assign bus.err_waw = err_waw_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
// Directed bench for reg_write_arbiter. Stimulus is applied just after each
// rising edge; expected bench-port writes are queued ahead of time and a
// monitor pops one whenever the DUT writes or accepts an MCU result, sampling
// on the falling edge. Level checks (stalls, ready, err_waw) are made inline.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  typedef struct packed {
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_word;
    logic        wb_link;
    logic        wb_set;
    logic        wb_cond;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        res_valid;
    logic [4:0]  res_rd;
    logic [31:0] res_word;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } stim_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] word;
    logic        link;
    logic        set;
    logic        cond;
    logic        mc_ready;
    logic        wb_stall;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  exp_t mon_got;
  exp_t mon_want;

  always #5 clk = ~clk;

  reg_write_arbiter_if bus ();

  reg_write_arbiter #(
    .STARVE_LIMIT    (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic exp_t expWb(input logic [4:0] rd, input logic [31:0] word,
                                 input logic link, input logic set, input logic cond);
    exp_t e;
    e          = '0;
    e.en       = 1'b1;
    e.rd       = rd;
    e.word     = word;
    e.link     = link;
    e.set      = set;
    e.cond     = cond;
    return e;
  endfunction

  function automatic exp_t expMc(input logic [4:0] rd, input logic [31:0] word,
                                 input logic stall);
    exp_t e;
    e          = '0;
    e.mc_ready = 1'b1;
    e.wb_stall = stall;
    if (rd != 5'd0) begin
      e.en   = 1'b1;
      e.rd   = rd;
      e.word = word;
    end
    return e;
  endfunction

  task automatic driveInputs(input stim_t s);
    bus.wb_valid       = s.wb_valid;
    bus.wb_rd          = s.wb_rd;
    bus.wb_word        = s.wb_word;
    bus.wb_link        = s.wb_link;
    bus.wb_set         = s.wb_set;
    bus.wb_cond        = s.wb_cond;
    bus.mc_issue_valid = s.iss_valid;
    bus.mc_issue_rd    = s.iss_rd;
    bus.mc_res_valid   = s.res_valid;
    bus.mc_res_rd      = s.res_rd;
    bus.mc_res_word    = s.res_word;
    bus.dec_rs1        = s.rs1;
    bus.dec_rs2        = s.rs2;
    bus.dec_rd         = s.rd;
  endtask

  // One cycle: drive after the rising edge, return at the falling edge.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    driveInputs(s);
    @(negedge clk);
  endtask

  task automatic expectWrite(input exp_t e);
    expq.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: any write or MCU acceptance must match the next
  // queued expectation.
  always @(negedge clk) begin
    if (!reset && ((bus.enable_reg === 1'b1) || (bus.mc_res_ready === 1'b1))) begin
      mon_got = {bus.enable_reg, bus.Rd_back, bus.word_back, bus.link_back,
                 bus.set_back, bus.condition_back, bus.mc_res_ready, bus.wb_stall};
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got %h expected none at %0t", mon_got, $time);
      end else begin
        mon_want = expq.pop_front();
        if (mon_got !== mon_want) begin
          errors++;
          $display("[TB] FAIL write_port: got %h expected %h at %0t", mon_got, mon_want, $time);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;

    // Reset state
    reset = 1'b1;
    driveInputs('0);
    @(negedge clk);
    checkOutput("reset_enable_reg", 32'(bus.enable_reg), 32'd0);
    checkOutput("reset_issue_ready", 32'(bus.mc_issue_ready), 32'd1);
    checkOutput("reset_err_waw", 32'(bus.err_waw), 32'd0);
    checkOutput("reset_dec_stall", 32'(bus.dec_stall), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // WB only: plain write, then a set-on-condition write
    s = '0; s.wb_valid = 1'b1; s.wb_rd = 5'd5; s.wb_word = 32'h1234;
    expectWrite(expWb(5'd5, 32'h1234, 1'b0, 1'b0, 1'b0));
    applyStimulus(s);
    checkOutput("wb_only_stall", 32'(bus.wb_stall), 32'd0);

    s = '0; s.wb_valid = 1'b1; s.wb_rd = 5'd6; s.wb_word = 32'hABCD;
    s.wb_set = 1'b1; s.wb_cond = 1'b1;
    expectWrite(expWb(5'd6, 32'hABCD, 1'b0, 1'b1, 1'b1));
    applyStimulus(s);

    // Hazard on pending rd=7, cleared by its MCU result
    s = '0; s.iss_valid = 1'b1; s.iss_rd = 5'd7;
    applyStimulus(s);
    checkOutput("issue_ready_empty", 32'(bus.mc_issue_ready), 32'd1);
    s = '0; s.rs2 = 5'd7;
    applyStimulus(s);
    checkOutput("hazard_rs2_pending", 32'(bus.dec_stall), 32'd1);
    s = '0; s.rs2 = 5'd7; s.res_valid = 1'b1; s.res_rd = 5'd7; s.res_word = 32'h77;
    expectWrite(expMc(5'd7, 32'h77, 1'b0));
    applyStimulus(s);
    checkOutput("hazard_during_retire", 32'(bus.dec_stall), 32'd1);
    s = '0; s.rs2 = 5'd7;
    applyStimulus(s);
    checkOutput("hazard_cleared", 32'(bus.dec_stall), 32'd0);

    // Starvation: WB wins 4 cycles, MCU forced on the 5th, WB retried on the 6th
    s = '0; s.iss_valid = 1'b1; s.iss_rd = 5'd8;
    applyStimulus(s);
    for (int i = 0; i < 6; i++) begin
      s = '0;
      s.wb_valid  = 1'b1;
      s.wb_rd     = 5'(10 + ((i < 4) ? i : 4));
      s.wb_word   = 32'h1000 + 32'(s.wb_rd);
      s.res_valid = (i < 5);
      s.res_rd    = 5'd8;
      s.res_word  = 32'h88;
      if (i == 4) expectWrite(expMc(5'd8, 32'h88, 1'b1));
      else        expectWrite(expWb(s.wb_rd, s.wb_word, 1'b0, 1'b0, 1'b0));
      applyStimulus(s);
    end

    // Outstanding limit
    s = '0; s.iss_valid = 1'b1; s.iss_rd = 5'd3;
    applyStimulus(s);
    s.iss_rd = 5'd4;
    applyStimulus(s);
    s = '0;
    applyStimulus(s);
    checkOutput("issue_ready_full", 32'(bus.mc_issue_ready), 32'd0);
    s = '0; s.iss_valid = 1'b1; s.iss_rd = 5'd5;
    applyStimulus(s);
    checkOutput("issue_full_stall", 32'(bus.dec_stall), 32'd1);
    s.res_valid = 1'b1; s.res_rd = 5'd3; s.res_word = 32'h33;
    expectWrite(expMc(5'd3, 32'h33, 1'b0));
    applyStimulus(s);
    checkOutput("issue_full_stall_retire", 32'(bus.dec_stall), 32'd1);
    s = '0; s.iss_valid = 1'b1; s.iss_rd = 5'd5;
    applyStimulus(s);
    checkOutput("issue_ready_after_retire", 32'(bus.mc_issue_ready), 32'd1);
    checkOutput("issue_stall_released", 32'(bus.dec_stall), 32'd0);
    s = '0; s.res_valid = 1'b1; s.res_rd = 5'd4; s.res_word = 32'h44;
    expectWrite(expMc(5'd4, 32'h44, 1'b0));
    applyStimulus(s);
    s.res_rd = 5'd5; s.res_word = 32'h55;
    expectWrite(expMc(5'd5, 32'h55, 1'b0));
    applyStimulus(s);

    // WAW on pending rd=9, sticky flag, then reset mid-WAIT
    s = '0; s.iss_valid = 1'b1; s.iss_rd = 5'd9;
    applyStimulus(s);
    s = '0; s.wb_valid = 1'b1; s.wb_rd = 5'd9; s.wb_word = 32'h99;
    expectWrite(expWb(5'd9, 32'h99, 1'b0, 1'b0, 1'b0));
    applyStimulus(s);
    checkOutput("err_waw_not_yet", 32'(bus.err_waw), 32'd0);
    s = '0;
    applyStimulus(s);
    checkOutput("err_waw_set", 32'(bus.err_waw), 32'd1);
    s = '0; s.wb_valid = 1'b1; s.wb_rd = 5'd1; s.wb_word = 32'h1;
    s.res_valid = 1'b1; s.res_rd = 5'd9; s.res_word = 32'h9;
    expectWrite(expWb(5'd1, 32'h1, 1'b0, 1'b0, 1'b0));
    applyStimulus(s);
    checkOutput("err_waw_sticky", 32'(bus.err_waw), 32'd1);

    s = '0; s.rs1 = 5'd9;
    @(posedge clk);
    #1;
    reset = 1'b1;
    driveInputs(s);
    @(negedge clk);
    checkOutput("midwait_reset_enable", 32'(bus.enable_reg), 32'd0);
    checkOutput("midwait_reset_err_waw", 32'(bus.err_waw), 32'd0);
    checkOutput("midwait_reset_scoreboard", 32'(bus.dec_stall), 32'd0);
    checkOutput("midwait_reset_ready", 32'(bus.mc_issue_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Link write to r31, then an MCU result for r0 that is accepted but dropped
    s = '0; s.wb_valid = 1'b1; s.wb_link = 1'b1; s.wb_word = 32'h100;
    expectWrite(expWb(5'd31, 32'h100, 1'b1, 1'b0, 1'b0));
    applyStimulus(s);
    s = '0; s.iss_valid = 1'b1; s.iss_rd = 5'd0;
    applyStimulus(s);
    s = '0; s.res_valid = 1'b1; s.res_rd = 5'd0; s.res_word = 32'hDEAD;
    expectWrite(expMc(5'd0, 32'hDEAD, 1'b0));
    applyStimulus(s);
    checkOutput("r0_result_no_enable", 32'(bus.enable_reg), 32'd0);
    s = '0;
    applyStimulus(s);
    checkOutput("link_no_waw", 32'(bus.err_waw), 32'd0);
    checkOutput("r0_retired_ready", 32'(bus.mc_issue_ready), 32'd1);

    checkOutput("expected_queue_drained", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Sequences the single write port of the 32-entry register bench between two requesters: the in-order pipeline writeback (WB) stage and a multi-cycle unit (MCU: mul/div).
- Keeps a per-register scoreboard of MCU destinations still in flight, and gives decode the hazard stall for any read or write of a pending register.
- Includes a starvation guard so MCU results cannot be blocked indefinitely by back-to-back WB writes.
- Sits between WB/MCU and the register bench write inputs.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles an MCU result may wait before it is force-granted.
- MAX_OUTSTANDING, 2, maximum MCU ops issued but not yet written back.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  WB write request (no handshake; held while wb_stall)
- wb_rd  in  5  WB destination
- wb_word  in  32  WB result
- wb_link  in  1  WB link write (targets r31, value word+4 applied by bench)
- wb_set  in  1  WB set-on-condition write
- wb_cond  in  1  WB condition bit
- wb_stall  out  1  WB must hold its request this cycle
- mc_issue_valid  in  1  decode issues an MCU op
- mc_issue_rd  in  5  MCU op destination
- mc_issue_ready  out  1  outstanding < MAX_OUTSTANDING
- mc_res_valid  in  1  MCU result available
- mc_res_rd  in  5  MCU result destination
- mc_res_word  in  32  MCU result
- mc_res_ready  out  1  MCU result written this cycle
- dec_rs1, dec_rs2, dec_rd  in  5 each  operands of the instruction in decode
- dec_stall  out  1  decode hazard on a pending register
- enable_reg  out  1  bench write enable
- Rd_back  out  5  bench write address
- word_back  out  32  bench write data
- link_back, set_back, condition_back  out  1 each  bench write qualifiers
- err_waw  out  1  sticky: WB wrote a register pending in the scoreboard

Behaviour:
- Reset (async, active-high): FSM=IDLE, scoreboard=0, outstanding=0, starve counter=0, err_waw=0.
- Write-port outputs are combinational from the current state and requests (zero added latency); the bench commits them on the next clk edge.
- FSM states:
  - IDLE: no MCU result waiting.
  - WAIT: MCU result blocked by WB; counter increments every cycle in WAIT.
  - FORCE: counter reached STARVE_LIMIT.
- Grant rules:
  - IDLE/WAIT, wb_valid=1: WB granted. If mc_res_valid also =1, go to (or stay in) WAIT; mc_res_ready=0.
  - IDLE/WAIT, wb_valid=0, mc_res_valid=1: MCU granted (mc_res_ready=1, link/set=0); go to IDLE; counter cleared.
  - FORCE: MCU granted unconditionally; wb_stall=1 if wb_valid; go to IDLE; counter cleared.
  - WAIT to FORCE transition happens when the counter, after increment, equals STARVE_LIMIT. With STARVE_LIMIT=4 the MCU waits at most 4 cycles and is written in the 5th.
- enable_reg=1 exactly when a grant occurs. Otherwise Rd_back, word_back and the qualifiers are 0.
- WB with wb_rd=0 and wb_link=0: still granted (bench ignores r0); no scoreboard effect.
- MCU result with mc_res_rd=0 is accepted and discarded (enable_reg=0).
- Scoreboard:
  - Set bit[mc_issue_rd] on mc_issue_valid && mc_issue_ready && rd!=0.
  - Clear bit[mc_res_rd] on the MCU grant.
  - Same-register set and clear in one cycle: set wins.
  - outstanding increments on accepted issue (including rd=0) and decrements on MCU grant; both in one cycle leaves it unchanged.
- dec_stall = (any nonzero dec_rs1/rs2/rd has its bit set) OR (mc_issue_valid && !mc_issue_ready).
- err_waw set when a WB grant targets a nonzero register whose bit is set, or when wb_link=1 and bit[31] is set. It is cleared only by reset.
- mc_res_valid deasserted while in WAIT (illegal): return to IDLE, counter cleared.
- Reset mid-wait: pending MCU result is lost; the MCU must be reset together with this block.

Decomposition:
- Shared package (cpu_pkg): REG_ADDR_W=5, NUM_REGS=32, LINK_REG=31, typedef arb_state_t {IDLE, WAIT, FORCE}, typedef struct wr_req_t {rd, word, link, set, cond}.
- One natural sub-module: reg_scoreboard, holding the pending bits and outstanding counter, with set/clear/lookup ports.

Test Plan:
- WB only: wb_valid, wb_rd=5, wb_word=0x1234 -> same cycle enable_reg=1, Rd_back=5, word_back=0x1234, wb_stall=0.
- Issue mc rd=7, then dec_rs2=7 -> dec_stall=1. MCU result rd=7 with WB idle -> mc_res_ready=1, Rd_back=7; next cycle dec_stall=0.
- Conflict: wb_valid and mc_res_valid together for 6 cycles, STARVE_LIMIT=4 -> WB granted on cycles 1-4, MCU force-granted on cycle 5 with wb_stall=1, WB granted on cycle 6.
- Issue rd=3 and rd=4 with MAX_OUTSTANDING=2 -> mc_issue_ready=0; a third issue request gives dec_stall=1 until one MCU result is written.
- Pending rd=9, WB writes rd=9 -> err_waw=1 and stays set; assert reset mid-WAIT -> all outputs 0, scoreboard cleared.
- WB link with wb_word=0x100 -> link_back=1, enable_reg=1; MCU result with rd=0 while WB idle -> mc_res_ready=1, enable_reg=0.
